// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants and types for the float-to-word converter
package fp_pkg;
   localparam int LOG_W  = 5;
   localparam int EXP_W  = 8;
   localparam int MANT_W = 23;

   localparam int unsigned EXP_BIAS     = 127;
   localparam int unsigned EXP_SHIFT0   = 150;
   localparam int unsigned EXP_MAX_NORM = 157;
   localparam int unsigned EXP_OVF      = 158;
   localparam int unsigned EXP_SPECIAL  = 255;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   typedef enum logic [2:0] {CLS_NORMAL, CLS_NAN, CLS_INF, CLS_SMALL, CLS_OVF} cls_t;
endpackage

// File: rtl/fp_unpack.sv
// rtl/fp_unpack.sv - splits a single-precision operand and classifies it
module fp_unpack
   import fp_pkg::*;
#(
   parameter int LOGWIDTH  = LOG_W,
   parameter int EXPWIDTH  = EXP_W,
   parameter int MANTWIDTH = MANT_W
) (
   input  logic [EXPWIDTH+MANTWIDTH:0] a,
   output logic                        sign,
   output logic [MANTWIDTH:0]          mant_h,
   output cls_t                        cls,
   output logic [LOGWIDTH-1:0]         shamt,
   output logic                        shl,
   output logic                        exact_min
);

   logic [EXPWIDTH-1:0]  exp_f;
   logic [MANTWIDTH-1:0] mant_f;
   int unsigned          e_i;

   assign sign   = a[EXPWIDTH+MANTWIDTH];
   assign exp_f  = a[MANTWIDTH +: EXPWIDTH];
   assign mant_f = a[MANTWIDTH-1:0];
   assign mant_h = {1'b1, mant_f};

   // Classify by exponent and derive the shift that aligns the binary point with bit 0
   always_comb begin
      e_i       = 32'(exp_f);
      cls       = CLS_NORMAL;
      shamt     = '0;
      shl       = 1'b0;
      exact_min = 1'b0;
      if (e_i == EXP_SPECIAL) begin
         cls = (mant_f != '0) ? CLS_NAN : CLS_INF;
      end else if (e_i < EXP_BIAS) begin
         cls = CLS_SMALL;
      end else if (e_i > EXP_MAX_NORM) begin
         cls       = CLS_OVF;
         exact_min = sign && (e_i == EXP_OVF) && (mant_f == '0);
      end else if (e_i >= EXP_SHIFT0) begin
         shl   = 1'b1;
         shamt = LOGWIDTH'(e_i - EXP_SHIFT0);
      end else begin
         shamt = LOGWIDTH'(EXP_SHIFT0 - e_i);
      end
   end

endmodule

// File: rtl/fp_cvt_seq.sv
// rtl/fp_cvt_seq.sv - sequential float-to-word conversion, one bit shift per cycle
module fp_cvt_seq
   import fp_pkg::*;
#(
   parameter int LOGWIDTH  = LOG_W,
   parameter int EXPWIDTH  = EXP_W,
   parameter int MANTWIDTH = MANT_W
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [EXPWIDTH+MANTWIDTH:0] diA,
   input  logic                        ciValid,
   output logic                        coReady,
   output logic [2**LOGWIDTH-1:0]      doY,
   output logic                        doNAN,
   output logic                        doINF,
   output logic                        doValid,
   input  logic                        ciReady
);

   localparam int WIDTH = 2**LOGWIDTH;
   localparam logic [WIDTH-1:0] INT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   state_t               state, state_n;
   logic [LOGWIDTH-1:0]  n;
   logic                 shl;
   logic [WIDTH-1:0]     mag;
   logic                 sign;
   logic                 forced;
   logic [WIDTH-1:0]     f_y;
   logic                 f_nan, f_inf;

   logic                 u_sign, u_shl, u_exact_min;
   logic [MANTWIDTH:0]   u_mant;
   cls_t                 u_cls;
   logic [LOGWIDTH-1:0]  u_shamt;

   logic                 acc_forced;
   logic [WIDTH-1:0]     acc_y;
   logic                 acc_nan, acc_inf;

   fp_unpack #(
      .LOGWIDTH  (LOGWIDTH),
      .EXPWIDTH  (EXPWIDTH),
      .MANTWIDTH (MANTWIDTH)
   ) u_unpack (
      .a         (diA),
      .sign      (u_sign),
      .mant_h    (u_mant),
      .cls       (u_cls),
      .shamt     (u_shamt),
      .shl       (u_shl),
      .exact_min (u_exact_min)
   );

   // Forced result for operands whose answer does not come from the shifter
   always_comb begin
      acc_forced = 1'b1;
      acc_y      = '0;
      acc_nan    = 1'b0;
      acc_inf    = 1'b0;
      case (u_cls)
         CLS_NAN: begin
            acc_y   = INT_MAX;
            acc_nan = 1'b1;
         end
         CLS_INF: begin
            acc_y   = u_sign ? INT_MIN : INT_MAX;
            acc_inf = 1'b1;
         end
         CLS_OVF: begin
            acc_y   = u_sign ? INT_MIN : INT_MAX;
            acc_inf = !u_exact_min;
         end
         CLS_SMALL: acc_y = '0;
         default:   acc_forced = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_n = state;
      coReady = 1'b0;
      doValid = 1'b0;
      case (state)
         S_IDLE: begin
            coReady = 1'b1;
            if (ciValid) state_n = S_SHIFT;
         end
         S_SHIFT: if (n == '0) state_n = S_DONE;
         S_DONE: begin
            doValid = 1'b1;
            if (ciReady) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Operand capture, serial shifting and result register
   always_ff @(posedge clk) begin
      if (!reset) begin
         n      <= '0;
         shl    <= 1'b0;
         mag    <= '0;
         sign   <= 1'b0;
         forced <= 1'b0;
         f_y    <= '0;
         f_nan  <= 1'b0;
         f_inf  <= 1'b0;
         doY    <= '0;
         doNAN  <= 1'b0;
         doINF  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (ciValid) begin
               sign   <= u_sign;
               mag    <= WIDTH'(u_mant);
               n      <= acc_forced ? '0 : u_shamt;
               shl    <= u_shl;
               forced <= acc_forced;
               f_y    <= acc_y;
               f_nan  <= acc_nan;
               f_inf  <= acc_inf;
            end
            S_SHIFT: begin
               if (n != '0) begin
                  mag <= shl ? (mag << 1) : (mag >> 1);
                  n   <= n - LOGWIDTH'(1);
               end else begin
                  doY   <= forced ? f_y : (sign ? ('0 - mag) : mag);
                  doNAN <= f_nan;
                  doINF <= f_inf;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_cvt_seq.sv
// tb/tb_fp_cvt_seq.sv - randomized and directed bench for fp_cvt_seq
module tb_fp_cvt_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] diA;
   logic        ciValid;
   logic        coReady;
   logic [31:0] doY;
   logic        doNAN;
   logic        doINF;
   logic        doValid;
   logic        ciReady;

   int passed = 0;
   int total  = 0;

   fp_cvt_seq dut (
      .clk     (clk),
      .reset   (reset),
      .diA     (diA),
      .ciValid (ciValid),
      .coReady (coReady),
      .doY     (doY),
      .doNAN   (doNAN),
      .doINF   (doINF),
      .doValid (doValid),
      .ciReady (ciReady)
   );

   always #5 clk = ~clk;

   // Reference: exact value of the float, truncated, then clamped to the word range
   function automatic void ref_cvt(input logic [31:0] a, output logic [31:0] y,
                                   output logic nan, output logic inf, output int lat);
      int     e;
      longint m, v;
      logic   s;
      s   = a[31];
      e   = int'(a[30:23]);
      m   = longint'({1'b1, a[22:0]});
      nan = 1'b0;
      inf = 1'b0;
      lat = 1;
      y   = 32'h0;
      if (e == 255) begin
         if (a[22:0] != 23'h0) begin
            y = 32'h7FFFFFFF; nan = 1'b1;
         end else begin
            y = s ? 32'h80000000 : 32'h7FFFFFFF; inf = 1'b1;
         end
      end else if (e < 127) begin
         y = 32'h0;
      end else begin
         if (e <= 157) lat = 1 + ((e >= 150) ? (e - 150) : (150 - e));
         if (e >= 160) v = 64'sd1 <<< 40;
         else if (e >= 150) v = m * (64'sd1 <<< (e - 150));
         else v = m / (64'sd1 <<< (150 - e));
         if (s) v = -v;
         if (v > 64'sd2147483647) begin
            y = 32'h7FFFFFFF; inf = 1'b1;
         end else if (v < -64'sd2147483648) begin
            y = 32'h80000000; inf = 1'b1;
         end else begin
            y = v[31:0];
         end
      end
   endfunction

   // Issue one operand, wait (bounded) for doValid, optionally release the result
   task automatic run_op(input logic [31:0] a, input logic hold, output logic [31:0] y,
                         output logic nan, output logic inf, output int lat);
      @(negedge clk);
      diA = a;
      ciValid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ciValid = 1'b0;
      lat = 0;
      while (!doValid && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      y   = doY;
      nan = doNAN;
      inf = doINF;
      if (!hold) begin
         ciReady = 1'b1;
         @(posedge clk);
         @(negedge clk);
         ciReady = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; ciValid = 1'b1; ciReady = 1'b0; diA = 32'h3F800000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (coReady !== 1'b1) $display("FAIL reset_coReady got %b want 1", coReady); else passed++;
      total++; if (doValid !== 1'b0) $display("FAIL reset_doValid got %b want 0", doValid); else passed++;
      total++; if (doY !== 32'h0) $display("FAIL reset_doY got %h want 00000000", doY); else passed++;
      total++; if (doNAN !== 1'b0) $display("FAIL reset_doNAN got %b want 0", doNAN); else passed++;
      total++; if (doINF !== 1'b0) $display("FAIL reset_doINF got %b want 0", doINF); else passed++;
      ciValid = 1'b0;
      reset = 1'b1;
   endtask

   task automatic test_directed();
      logic [31:0] va [9] = '{32'h3F800000, 32'hC2F6E979, 32'h3F000000, 32'h4EFFFFFF, 32'hCF000000,
                             32'h4F000000, 32'hFF800000, 32'h7FC00000, 32'h80000000};
      logic [31:0] vy [9] = '{32'h00000001, 32'hFFFFFF85, 32'h00000000, 32'h7FFFFF80, 32'h80000000,
                             32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000000};
      logic        vn [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
      logic        vi [9] = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
      int          vl [9] = '{24, 18, 1, 8, 1, 1, 1, 1, 1};
      logic [31:0] y;
      logic        nan, inf;
      int          lat;
      for (int i = 0; i < 9; i++) begin
         run_op(va[i], 1'b0, y, nan, inf, lat);
         total++; if (y !== vy[i]) $display("FAIL dir_y[%h] got %h want %h", va[i], y, vy[i]); else passed++;
         total++; if (nan !== vn[i]) $display("FAIL dir_nan[%h] got %b want %b", va[i], nan, vn[i]); else passed++;
         total++; if (inf !== vi[i]) $display("FAIL dir_inf[%h] got %b want %b", va[i], inf, vi[i]); else passed++;
         total++; if (lat != vl[i]) $display("FAIL dir_lat[%h] got %0d want %0d", va[i], lat, vl[i]); else passed++;
      end
   endtask

   task automatic test_random();
      logic [31:0] a, y, ey;
      logic        nan, inf, en, ei;
      int          lat, el;
      for (int i = 0; i < 200; i++) begin
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[30:23] = 8'($urandom_range(120, 165));
         if ($urandom_range(0, 7) == 0) a[22:0] = 23'h0;
         ref_cvt(a, ey, en, ei, el);
         run_op(a, 1'b0, y, nan, inf, lat);
         total++; if (y !== ey) $display("FAIL rnd_y[%h] got %h want %h", a, y, ey); else passed++;
         total++; if (nan !== en) $display("FAIL rnd_nan[%h] got %b want %b", a, nan, en); else passed++;
         total++; if (inf !== ei) $display("FAIL rnd_inf[%h] got %b want %b", a, inf, ei); else passed++;
         total++; if (lat != el) $display("FAIL rnd_lat[%h] got %0d want %0d", a, lat, el); else passed++;
      end
   endtask

   task automatic test_hold();
      logic [31:0] y, ey;
      logic        nan, inf, en, ei;
      int          lat, el;
      ref_cvt(32'hC2F6E979, ey, en, ei, el);
      run_op(32'hC2F6E979, 1'b1, y, nan, inf, lat);
      total++; if (y !== ey) $display("FAIL hold_y got %h want %h", y, ey); else passed++;
      for (int i = 0; i < 3; i++) begin
         diA = 32'h40400000; ciValid = 1'b1; ciReady = 1'b0;
         @(posedge clk);
         @(negedge clk);
         total++; if (doValid !== 1'b1) $display("FAIL hold_valid[%0d] got %b want 1", i, doValid); else passed++;
         total++; if (coReady !== 1'b0) $display("FAIL hold_coReady[%0d] got %b want 0", i, coReady); else passed++;
         total++; if (doY !== ey) $display("FAIL hold_doY[%0d] got %h want %h", i, doY, ey); else passed++;
         total++; if ({doNAN, doINF} !== {en, ei}) $display("FAIL hold_flags[%0d] got %b%b want %b%b", i, doNAN, doINF, en, ei); else passed++;
      end
      ciValid = 1'b0; ciReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ciReady = 1'b0;
      total++; if (coReady !== 1'b1) $display("FAIL release_coReady got %b want 1", coReady); else passed++;
      total++; if (doValid !== 1'b0) $display("FAIL release_doValid got %b want 0", doValid); else passed++;
      total++; if (doY !== ey) $display("FAIL release_doY_held got %h want %h", doY, ey); else passed++;
      @(posedge clk);
      @(negedge clk);
      total++; if (coReady !== 1'b1) $display("FAIL ignored_ciValid_coReady got %b want 1", coReady); else passed++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] y, ey;
      logic        nan, inf, en, ei, seen;
      int          lat, el;
      @(negedge clk);
      diA = 32'h3F800000; ciValid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ciValid = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      total++; if (coReady !== 1'b1) $display("FAIL midrst_coReady got %b want 1", coReady); else passed++;
      total++; if (doY !== 32'h0) $display("FAIL midrst_doY got %h want 00000000", doY); else passed++;
      seen = doValid;
      repeat (30) begin
         @(negedge clk);
         if (doValid) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) $display("FAIL midrst_no_valid got %b want 0", seen); else passed++;
      ref_cvt(32'h40400000, ey, en, ei, el);
      run_op(32'h40400000, 1'b0, y, nan, inf, lat);
      total++; if (y !== 32'h00000003) $display("FAIL after_rst_y got %h want 00000003", y); else passed++;
      total++; if ({nan, inf} !== {en, ei}) $display("FAIL after_rst_flags got %b%b want %b%b", nan, inf, en, ei); else passed++;
      total++; if (lat != el) $display("FAIL after_rst_lat got %0d want %0d", lat, el); else passed++;
   endtask

   initial begin
      reset = 1'b0; ciValid = 1'b0; ciReady = 1'b0; diA = 32'h0;
      test_reset();
      test_directed();
      test_hold();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fp_cvt_seq.md
FP_CVT_SEQ -- requirements
Module: fp_cvt_seq

Interface
REQ-001 SHALL have parameter LOGWIDTH, default 5, data width exponent (width = 2**LOGWIDTH = 32).
REQ-002 SHALL have parameter EXPWIDTH, default 8, IEEE754 exponent field width.
REQ-003 SHALL have parameter MANTWIDTH, default 23, IEEE754 fraction field width.
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port diA  input  32  IEEE754 single operand.
REQ-007 SHALL have port ciValid  input  1  operand valid.
REQ-008 SHALL have port coReady  output  1  block can accept an operand.
REQ-009 SHALL have port doY  output  32  two's-complement word result.
REQ-010 SHALL have port doNAN  output  1  operand was NaN.
REQ-011 SHALL have port doINF  output  1  operand infinite, or result saturated.
REQ-012 SHALL have port doValid  output  1  result valid.
REQ-013 SHALL have port ciReady  input  1  consumer accepts result.

Function
REQ-014 SHALL convert float to word (cvt.w.s), truncating toward zero; one operation in flight, no overlap.
REQ-015 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE; coReady = 1 only in IDLE.
REQ-016 Accept SHALL occur on an edge with IDLE & ciValid; ciValid outside IDLE SHALL be ignored.
REQ-017 On accept: s, e, m unpacked; mag loaded with {1,m} (24 bits, zero-extended to 32); shift count N and direction loaded; next state SHIFT.
REQ-018 Normal range 127 <= e <= 157: e >= 150 -> left shift, N = e-150 (0..7); e < 150 -> right shift, N = 150-e (1..23).
REQ-019 Special cases SHALL load N = 0 and a forced result: NaN (e=255, m!=0) -> doY 7FFFFFFF, doNAN 1; Inf (e=255, m=0) -> doY 7FFFFFFF (s=0) / 80000000 (s=1), doINF 1; e < 127 (zero, denormal, |x|<1) -> doY 00000000; e >= 158 -> saturate as Inf with doINF 1, except s=1, e=158, m=0 -> doY 80000000, doINF 0.
REQ-020 In SHIFT with N != 0: mag shifted by exactly one bit in the loaded direction, N decremented, per edge.
REQ-021 In SHIFT with N = 0: doY registered as s ? -mag : mag (or the forced value), flags registered, next state DONE.
REQ-022 Latency: doValid SHALL rise N+1 edges after the accept edge (1 to 24 cycles).
REQ-023 In DONE: doValid = 1; doY/doNAN/doINF stable until an edge with ciReady = 1, which returns to IDLE (coReady = 1 next cycle).
REQ-024 Outside DONE: doValid = 0; doY, doNAN, doINF hold their last values.
REQ-025 Negative zero SHALL produce 00000000 with both flags 0.

Reset
REQ-026 reset = 0 at an edge SHALL force IDLE, N = 0, doY = 0, doNAN = 0, doINF = 0, doValid = 0, coReady = 1 next cycle, from any state.
REQ-027 Reset mid-SHIFT or mid-DONE SHALL discard the operation, with no result ever presented.

Structure
REQ-028 Package fp_pkg SHALL hold the exponent bias (127), field-width constants, the special-case exponent constants (150, 157, 158, 255), and the FSM state enum.
REQ-029 Combinational sub-module fp_unpack SHALL split the operand and classify it (nan/inf/small/ovf/normal), and SHALL output N and the shift direction; the FSM and shifter stay in fp_cvt_seq.

Verification
REQ-030 3F800000 -> doY 00000001, flags 0, doValid 24 cycles after accept.
REQ-031 C2F6E979 (-123.456) -> doY FFFFFF85, valid 18 cycles after accept; 3F000000 (0.5) -> 00000000, valid after 1 cycle.
REQ-032 4EFFFFFF -> doY 7FFFFF80 after 8 cycles; CF000000 -> 80000000, INF 0; 4F000000 -> 7FFFFFFF, INF 1; FF800000 -> 80000000, INF 1.
REQ-033 7FC00000 -> doY 7FFFFFFF, NAN 1, INF 0; 80000000 (-0) -> 00000000, flags 0.
REQ-034 Hold ciReady = 0 for 3 cycles in DONE -> doY and flags stable, coReady 0, and a new ciValid is ignored; ciReady = 1 -> IDLE next cycle.
REQ-035 Drive reset = 0 during the SHIFT of 3F800000 -> IDLE, doValid never asserted; the next operand 40400000 -> 00000003.
